// File: rtl/fmul_arbiter_pkg.sv
// Shared fp32 field layout and index-width helper for the multiplier arbiter slice.
package fmul_arbiter_pkg;

   localparam int FP_W       = 32;
   localparam int FP_SIGN_W  = 1;
   localparam int FP_EXP_W   = 8;
   localparam int FP_MAN_W   = 23;
   localparam int FP_BIAS    = 127;
   localparam int FP_EXP_MAX = 255;

   // Width of an index into n entries, never narrower than one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fmul_arbiter_core.sv
// fp32 multiplier for normal operands, round-toward-zero, with MUL_LAT register stages.
module fmul_core
   import fmul_arbiter_pkg::*;
#(
   parameter int MUL_LAT = 1
) (
   input  logic            clk,
   input  logic [FP_W-1:0] in0,
   input  logic [FP_W-1:0] in1,
   output logic [FP_W-1:0] res
);

   logic                sign;
   logic [FP_EXP_W-1:0] exp0, exp1;
   logic [FP_MAN_W:0]   man0, man1;
   logic [47:0]         prod;
   logic [47:0]         norm;
   logic [FP_MAN_W-1:0] man_out;
   int                  exp_out;
   logic [FP_W-1:0]     comb_res;
   logic [FP_W-1:0]     pipe [MUL_LAT];

   assign sign = in0[FP_W-1] ^ in1[FP_W-1];
   assign exp0 = in0[FP_W-2 -: FP_EXP_W];
   assign exp1 = in1[FP_W-2 -: FP_EXP_W];
   assign man0 = {1'b1, in0[FP_MAN_W-1:0]};
   assign man1 = {1'b1, in1[FP_MAN_W-1:0]};
   assign prod = {24'b0, man0} * {24'b0, man1};

   // Product of two [1,2) significands lies in [1,4); normalise by one bit when it reaches 2.
   always_comb begin
      norm     = prod[47] ? prod : (prod << 1);
      man_out  = FP_MAN_W'(norm >> 24);
      exp_out  = int'(exp0) + int'(exp1) - FP_BIAS + int'(prod[47]);
      comb_res = {sign, {(FP_W-1){1'b0}}};
      if (exp0 == '0 || exp1 == '0 || exp_out <= 0) begin
         comb_res = {sign, {(FP_W-1){1'b0}}};
      end else if (exp_out >= FP_EXP_MAX) begin
         comb_res = {sign, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};
      end else begin
         comb_res = {sign, FP_EXP_W'(exp_out), man_out};
      end
   end

   always_ff @(posedge clk) begin
      pipe[0] <= comb_res;
      for (int k = 1; k < MUL_LAT; k++) begin
         pipe[k] <= pipe[k-1];
      end
   end

   assign res = pipe[MUL_LAT-1];

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one fp32 multiplier, with credit-based result FIFO.
module fmul_arbiter
   import fmul_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int MUL_LAT     = 1,
   parameter int OFIFO_DEPTH = MUL_LAT + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*32-1:0]        req_a,
   input  logic [NUM_REQ*32-1:0]        req_b,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [31:0]                  rsp_data,
   output logic [id_width(NUM_REQ)-1:0] rsp_id,
   output logic                         busy
);

   localparam int ID_W  = id_width(NUM_REQ);
   localparam int PTR_W = id_width(OFIFO_DEPTH);
   localparam int CNT_W = $clog2(OFIFO_DEPTH + 1);

   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W:0]    pick;
   logic [ID_W-1:0]  gnt_idx;
   logic             grant;
   logic             credit_ok;
   logic [31:0]      op_a, op_b, mul_res;
   logic [MUL_LAT-1:0] vld;
   logic [ID_W-1:0]  idsr [MUL_LAT];
   logic [CNT_W-1:0] inflight, count;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [ID_W-1:0]  mem_id   [OFIFO_DEPTH];
   logic [31:0]      mem_data [OFIFO_DEPTH];
   logic             push, pop;

   // Returns {found, index} of the first valid requester at or after ptr, wrapping.
   function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [ID_W-1:0] ptr);
      logic [ID_W:0] r;
      int            j;
      r = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!r[ID_W] && v[j]) r = {1'b1, ID_W'(j)};
      end
      return r;
   endfunction

   // Occupancy is taken from registered counts, so a pop this cycle frees credit only next cycle.
   assign credit_ok = (int'(inflight) + int'(count)) < OFIFO_DEPTH;
   assign pick      = rr_pick(req_valid, rr_ptr);
   assign gnt_idx   = pick[ID_W-1:0];
   assign grant     = pick[ID_W] && credit_ok && !rst;
   assign req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign op_a      = req_a[32*int'(gnt_idx) +: 32];
   assign op_b      = req_b[32*int'(gnt_idx) +: 32];

   fmul_core #(.MUL_LAT(MUL_LAT)) u_core (
      .clk (clk),
      .in0 (op_a),
      .in1 (op_b),
      .res (mul_res)
   );

   assign push      = vld[MUL_LAT-1];
   assign rsp_valid = (count != '0) && !rst;
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;
   assign rsp_id    = rsp_valid ? mem_id[rd_ptr] : '0;
   assign busy      = ((inflight != '0) || (count != '0)) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         vld      <= '0;
         inflight <= '0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         if (grant) rr_ptr <= ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
         vld[0] <= grant;
         for (int k = 1; k < MUL_LAT; k++) begin
            vld[k] <= vld[k-1];
         end
         inflight <= inflight + CNT_W'(grant) - CNT_W'(push);
         count    <= count + CNT_W'(push) - CNT_W'(pop);
         if (push) wr_ptr <= (wr_ptr == PTR_W'(OFIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PTR_W'(OFIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      end
   end

   // Ids ride alongside the multiplier stages; storage needs no reset since valids gate it.
   always_ff @(posedge clk) begin
      idsr[0] <= gnt_idx;
      for (int k = 1; k < MUL_LAT; k++) begin
         idsr[k] <= idsr[k-1];
      end
      if (push) begin
         mem_id[wr_ptr]   <= idsr[MUL_LAT-1];
         mem_data[wr_ptr] <= mul_res;
      end
   end

   fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && count == CNT_W'(OFIFO_DEPTH)));

endmodule

// File: tb/tb_fmul_arbiter.sv
// Directed bench for fmul_arbiter: vector table of single products plus multi-cycle sequences.
module tb_fmul_arbiter;

   localparam int NUM_REQ = 4;
   localparam int MUL_LAT = 1;
   localparam int DEPTH   = 2;

   localparam logic [31:0] F1P0 = 32'h3F800000;
   localparam logic [31:0] F1P5 = 32'h3FC00000;
   localparam logic [31:0] F2P0 = 32'h40000000;
   localparam logic [31:0] F3P0 = 32'h40400000;
   localparam logic [31:0] F4P0 = 32'h40800000;

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] prod;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_a, req_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [31:0]  rsp_data;
   logic [1:0]   rsp_id;
   logic         busy;

   int vec_count   = 0;
   int miscompares = 0;
   vec_t vecs [7];
   logic [31:0] bvals [4];

   always #5 clk = ~clk;

   fmul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT), .OFIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   // Inputs change just after the falling edge; outputs are sampled 1ns later.
   task automatic applyStimulus(input logic [3:0] valid, input logic [127:0] a,
                                input logic [127:0] b, input logic ready);
      @(negedge clk);
      req_valid = valid;
      req_a     = a;
      req_b     = b;
      rsp_ready = ready;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_rsp_data", rsp_data, 32'h0);
      checkOutput("rst_rsp_id", 32'(rsp_id), 32'h0);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 4'h0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && busy; i++) begin
         applyStimulus(4'h0, '0, '0, 1'b1);
      end
      checkOutput("drain_busy", 32'(busy), 32'h0);
   endtask

   initial begin
      int g, r, acc;

      rst       = 1'b1;
      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      vecs[0] = '{0, F1P0,         F2P0,         32'h40000000};
      vecs[1] = '{3, 32'hC0000000, F3P0,         32'hC0C00000};
      vecs[2] = '{1, F1P5,         F1P5,         32'h40100000};
      vecs[3] = '{2, 32'h80000000, F3P0,         32'h80000000};
      vecs[4] = '{1, F2P0,         32'h3F000000, 32'h3F800000};
      vecs[5] = '{0, F3P0,         F3P0,         32'h41100000};
      vecs[6] = '{2, 32'hBF800000, 32'hBF800000, 32'h3F800000};
      bvals   = '{F1P0, F2P0, F3P0, F4P0};

      applyReset();

      // Single operations: handshake, two-cycle latency, then idle.
      foreach (vecs[i]) begin
         applyStimulus(4'(1 << vecs[i].id), {4{vecs[i].a}}, {4{vecs[i].b}}, 1'b1);
         checkOutput("vec_grant", 32'(req_ready), 32'(1 << vecs[i].id));
         applyStimulus(4'h0, '0, '0, 1'b1);
         checkOutput("vec_early_valid", 32'(rsp_valid), 32'h0);
         checkOutput("vec_busy", 32'(busy), 32'h1);
         applyStimulus(4'h0, '0, '0, 1'b1);
         checkOutput("vec_valid", 32'(rsp_valid), 32'h1);
         checkOutput("vec_data", rsp_data, vecs[i].prod);
         checkOutput("vec_id", 32'(rsp_id), 32'(vecs[i].id));
         applyStimulus(4'h0, '0, '0, 1'b1);
         checkOutput("vec_idle_valid", 32'(rsp_valid), 32'h0);
         checkOutput("vec_idle_busy", 32'(busy), 32'h0);
      end

      // All four requesting from a fresh pointer: grants and responses rotate 0..3.
      applyReset();
      g = 0;
      r = 0;
      for (int cyc = 0; cyc < 80 && r < 8; cyc++) begin
         applyStimulus((g < 8) ? 4'hF : 4'h0, {4{F1P0}},
                       {bvals[3], bvals[2], bvals[1], bvals[0]}, 1'b1);
         if (req_ready != 4'h0) begin
            checkOutput("fair_grant", 32'(req_ready), 32'(1 << (g % 4)));
            g++;
         end
         if (rsp_valid) begin
            checkOutput("fair_id", 32'(rsp_id), 32'(r % 4));
            checkOutput("fair_data", rsp_data, bvals[r % 4]);
            r++;
         end
      end
      checkOutput("fair_rsp_count", 32'(r), 32'd8);
      drain();

      // Stalled consumer: only DEPTH requests fit, results held stable, then delivered once each.
      acc = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         applyStimulus(4'b0100, {4{F1P5}}, {4{F1P5}}, 1'b0);
         if (req_ready[2]) acc++;
         if (rsp_valid) checkOutput("bp_hold_data", rsp_data, 32'h40100000);
      end
      checkOutput("bp_accepted", 32'(acc), 32'(DEPTH));
      checkOutput("bp_ready_low", 32'(req_ready), 32'h0);
      checkOutput("bp_stalled_valid", 32'(rsp_valid), 32'h1);
      r = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         applyStimulus(4'h0, '0, '0, 1'b1);
         if (rsp_valid) begin
            checkOutput("bp_data", rsp_data, 32'h40100000);
            checkOutput("bp_id", 32'(rsp_id), 32'd2);
            r++;
         end
      end
      checkOutput("bp_rsp_count", 32'(r), 32'(DEPTH));
      checkOutput("bp_busy", 32'(busy), 32'h0);

      // Pointer at 3 after a grant to 2: requesters 0 and 3 resolve as 3 then 0.
      applyStimulus(4'b0100, {4{F1P0}}, {4{F1P0}}, 1'b1);
      checkOutput("wrap_setup", 32'(req_ready), 32'b0100);
      g = 0;
      for (int cyc = 0; cyc < 10 && g < 2; cyc++) begin
         applyStimulus(4'b1001, {4{F1P0}}, {4{F1P0}}, 1'b1);
         if (req_ready != 4'h0) begin
            checkOutput("wrap_grant", 32'(req_ready), (g == 0) ? 32'b1000 : 32'b0001);
            g++;
         end
      end
      checkOutput("wrap_grant_count", 32'(g), 32'd2);
      drain();

      // Reset one cycle after a grant discards the operation.
      applyStimulus(4'b0001, {4{F1P0}}, {4{F2P0}}, 1'b1);
      checkOutput("mid_grant", 32'(req_ready), 32'b0001);
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 4'h0;
      #1;
      checkOutput("mid_rst_valid", 32'(rsp_valid), 32'h0);
      checkOutput("mid_rst_busy", 32'(busy), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         applyStimulus(4'h0, '0, '0, 1'b1);
         checkOutput("mid_post_valid", 32'(rsp_valid), 32'h0);
         checkOutput("mid_post_busy", 32'(busy), 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
